// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage built as a 2-entry skid buffer with valid/ready on both sides.
// Flush squashes held entries; a saturating counter tracks decode backpressure cycles.
module ifid_skid_stage #(
  parameter int                  PC_W      = 32,
  parameter int                  INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
  parameter int                  CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [1:0]         count_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]         r_count;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [PC_W-1:0]    r_head_pc;
  logic [INSTR_W-1:0] r_head_instr;
  logic [PC_W-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_next_count;
  logic       w_head_from_in;
  logic       w_head_from_skid;
  logic       w_skid_from_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    w_push           = in_valid_i & r_in_ready;
    w_pop            = r_out_valid & out_ready_i;
    w_next_count     = r_count;
    w_head_from_in   = 1'b0;
    w_head_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_count)
      S_EMPTY: begin
        if (w_push) begin
          w_next_count   = S_ONE;
          w_head_from_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          w_head_from_in = 1'b1;
        end else if (w_push) begin
          w_next_count   = S_FULL;
          w_skid_from_in = 1'b1;
        end else if (w_pop) begin
          w_next_count = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_next_count     = S_ONE;
          w_head_from_skid = 1'b1;
        end
      end
      default: w_next_count = S_EMPTY;
    endcase
    // Flush wins over everything; a pop this cycle has already been taken by decode.
    if (flush_i) begin
      w_next_count     = S_EMPTY;
      w_head_from_in   = 1'b0;
      w_head_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_count     <= w_next_count;
      r_in_ready  <= (w_next_count != S_FULL);
      r_out_valid <= (w_next_count != S_EMPTY);
      if (r_out_valid && !out_ready_i) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
    end
  end

  // Head drives the outputs directly, so it is cleared to a bubble on reset and flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head_pc    <= '0;
      r_head_instr <= NOP_INSTR;
    end else if (flush_i) begin
      r_head_pc    <= '0;
      r_head_instr <= NOP_INSTR;
    end else if (w_head_from_in) begin
      r_head_pc    <= pc_i;
      r_head_instr <= instr_i;
    end else if (w_head_from_skid) begin
      r_head_pc    <= r_skid_pc;
      r_head_instr <= r_skid_instr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_skid_from_in) begin
      r_skid_pc    <= pc_i;
      r_skid_instr <= instr_i;
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign pc_o        = r_head_pc;
  assign instr_o     = r_head_instr;
  assign count_o     = r_count;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Scoreboard bench for ifid_skid_stage: directed scenarios plus a random valid/ready/flush run.
module tb_ifid_skid_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [1:0]  count_o;
  logic [3:0]  stall_cnt_o;

  ifid_skid_stage #(
    .PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .instr_i(instr_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .instr_o(instr_o), .count_o(count_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t       q[$];
  logic [3:0]  m_stall;
  logic        m_flushed;
  int          n_chk;
  int          n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return 32'h0050_0093 ^ pc;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    in_valid_i  = v;
    pc_i        = pc;
    instr_i     = mk_instr(pc);
    out_ready_i = rdy;
    flush_i     = fl;
  endtask

  // Monitor: checks state after the last edge, then models the coming edge.
  always @(negedge clk) begin
    item_t e;
    if (rst_i) begin
      q.delete();
      m_stall   = '0;
      m_flushed = 1'b0;
      chk("rst_count", {30'd0, count_o}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_instr", instr_o, NOP);
      chk("rst_stall", {28'd0, stall_cnt_o}, 32'd0);
    end else begin
      chk("count", {30'd0, count_o}, q.size());
      chk("out_valid", {31'd0, out_valid_o}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, in_ready_o}, {31'd0, q.size() != 2});
      chk("stall_cnt", {28'd0, stall_cnt_o}, {28'd0, m_stall});
      if (m_flushed) begin
        chk("flush_pc", pc_o, 32'd0);
        chk("flush_instr", instr_o, NOP);
      end
      if (out_valid_o && out_ready_i) begin
        if (q.size() == 0) begin
          chk("pop_empty", pc_o, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("pop_pc", pc_o, e.pc);
          chk("pop_instr", instr_o, e.instr);
        end
      end
      if (out_valid_o && !out_ready_i && m_stall != 4'hF) m_stall = m_stall + 4'd1;
      m_flushed = flush_i;
      if (flush_i) q.delete();
      else if (in_valid_i && in_ready_o) begin
        e.pc    = pc_i;
        e.instr = instr_i;
        q.push_back(e);
      end
    end
  end

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    m_stall   = '0;
    m_flushed = 1'b0;
    rst_i     = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1 rst_i = 1'b1;
    repeat (3) cycle();
    rst_i = 1'b0;

    // Stream
    drive(1'b1, 32'h00, 1'b1, 1'b0); cycle();
    chk("s1_count", {30'd0, count_o}, 32'd1); chk("s1_pc0", pc_o, 32'h00);
    drive(1'b1, 32'h04, 1'b1, 1'b0); cycle();
    chk("s1_pc4", pc_o, 32'h04); chk("s1_count_b", {30'd0, count_o}, 32'd1);
    drive(1'b1, 32'h08, 1'b1, 1'b0); cycle();
    chk("s1_pc8", pc_o, 32'h08); chk("s1_instr8", instr_o, 32'h0050_009B);
    drive(1'b0, 32'h00, 1'b1, 1'b0); cycle();
    chk("s1_drain", {30'd0, count_o}, 32'd0);

    // Backpressure
    drive(1'b1, 32'h10, 1'b0, 1'b0); cycle();
    chk("s2_count1", {30'd0, count_o}, 32'd1); chk("s2_stall0", {28'd0, stall_cnt_o}, 32'd0);
    drive(1'b1, 32'h14, 1'b0, 1'b0); cycle();
    chk("s2_count2", {30'd0, count_o}, 32'd2); chk("s2_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("s2_hold", pc_o, 32'h10); chk("s2_stall1", {28'd0, stall_cnt_o}, 32'd1);
    drive(1'b0, 32'h00, 1'b0, 1'b0); cycle();
    chk("s2_stall2", {28'd0, stall_cnt_o}, 32'd2); chk("s2_hold_b", pc_o, 32'h10);
    drive(1'b0, 32'h00, 1'b1, 1'b0); cycle();
    chk("s2_next", pc_o, 32'h14); chk("s2_count_b", {30'd0, count_o}, 32'd1);
    cycle();
    chk("s2_empty", {30'd0, count_o}, 32'd0);

    // Flush while full, with a push attempt in the flush cycle
    drive(1'b1, 32'h18, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h1C, 1'b0, 1'b0); cycle();
    chk("s3_full", {30'd0, count_o}, 32'd2);
    drive(1'b1, 32'h20, 1'b0, 1'b1); cycle();
    chk("s3_count", {30'd0, count_o}, 32'd0); chk("s3_pc", pc_o, 32'd0);
    chk("s3_instr", instr_o, NOP); chk("s3_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("s3_stall4", {28'd0, stall_cnt_o}, 32'd4);
    drive(1'b0, 32'h00, 1'b1, 1'b0); cycle();
    chk("s3_no_0x20", {31'd0, out_valid_o}, 32'd0);

    // Counter saturation
    drive(1'b1, 32'h24, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h00, 1'b0, 1'b0);
    repeat (20) cycle();
    chk("s4_sat", {28'd0, stall_cnt_o}, 32'hF);
    drive(1'b0, 32'h00, 1'b0, 1'b1); cycle();
    chk("s4_sat_flush", {28'd0, stall_cnt_o}, 32'hF); chk("s4_count", {30'd0, count_o}, 32'd0);
    drive(1'b0, 32'h00, 1'b1, 1'b0); cycle();

    // Asynchronous reset mid-cycle while full
    drive(1'b1, 32'h30, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h34, 1'b0, 1'b0); cycle();
    chk("s5_full", {30'd0, count_o}, 32'd2);
    #2 rst_i = 1'b1;
    #1;
    chk("s5_count", {30'd0, count_o}, 32'd0); chk("s5_valid", {31'd0, out_valid_o}, 32'd0);
    chk("s5_ready", {31'd0, in_ready_o}, 32'd1); chk("s5_pc", pc_o, 32'd0);
    chk("s5_instr", instr_o, NOP); chk("s5_stall", {28'd0, stall_cnt_o}, 32'd0);
    drive(1'b0, 32'h00, 1'b0, 1'b0);
    cycle();
    rst_i = 1'b0;
    drive(1'b1, 32'h40, 1'b0, 1'b0); cycle();
    chk("s5_valid40", {31'd0, out_valid_o}, 32'd1); chk("s5_pc40", pc_o, 32'h40);
    drive(1'b0, 32'h00, 1'b1, 1'b0); cycle();

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      instr_i = $urandom;
      cycle();
    end
    drive(1'b0, 32'h00, 1'b1, 1'b0);
    repeat (4) cycle();
    chk("s6_drained", {30'd0, count_o}, 32'd0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
